// File: rtl/cacheline_adaptor_p_if.sv
// Bus bundle for cacheline_adaptor_p: the cache-side line request port plus the
// physical-memory burst port. The adaptor uses "slave"; the requester/memory side uses "master".
`timescale 1ns/1ps
interface cacheline_adaptor_p_if #(
    parameter int s_line  = 256,
    parameter int s_burst = 64
);
    logic [s_line-1:0]  line_i;
    logic [s_line-1:0]  line_o;
    logic [31:0]        address_i;
    logic               read_i;
    logic               write_i;
    logic               resp_o;
    logic               busy_o;
    logic [s_burst-1:0] burst_i;
    logic [s_burst-1:0] burst_o;
    logic [31:0]        address_o;
    logic               read_o;
    logic               write_o;
    logic               resp_i;

    modport slave (
        input  line_i, address_i, read_i, write_i, burst_i, resp_i,
        output line_o, resp_o, busy_o, burst_o, address_o, read_o, write_o
    );

    modport master (
        output line_i, address_i, read_i, write_i, burst_i, resp_i,
        input  line_o, resp_o, busy_o, burst_o, address_o, read_o, write_o
    );
endinterface

// File: rtl/cacheline_adaptor_p.sv
// Converts whole-cacheline fill/writeback requests into 4-beat memory bursts.
// Define CACHELINE_ADAPTOR_POSTED_WRITE_EN to acknowledge writebacks right after accept.
`timescale 1ns/1ps
module cacheline_adaptor_p #(
    parameter int s_line    = 256,
    parameter int s_burst   = 64,
    parameter int num_beats = 4
) (
    input logic clk,
    input logic rst,
    cacheline_adaptor_p_if.slave bus
);
    localparam int cnt_w = $clog2(num_beats);
    localparam logic [31:0] line_mask = ~32'(s_line / 8 - 1);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t             state;
    state_t             next_state;
    logic [cnt_w-1:0]   cnt;
    logic [31:0]        addr;
    logic [s_line-1:0]  wbuf;
    logic [s_line-1:0]  line;
    logic               last_beat;

    assign last_beat = bus.resp_i && (cnt == cnt_w'(num_beats - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            // Writeback first: a dirty victim must reach memory before its fill.
            IDLE: begin
                if (bus.write_i) begin
                    next_state = WR;
                end else if (bus.read_i) begin
                    next_state = RD;
                end
            end
            RD: begin
                if (last_beat) begin
                    next_state = DONE;
                end
            end
            WR: begin
                if (last_beat) begin
`ifdef CACHELINE_ADAPTOR_POSTED_WRITE_EN
                    next_state = IDLE;
`else
                    next_state = DONE;
`endif
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            addr <= '0;
            wbuf <= '0;
            line <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (bus.write_i || bus.read_i) begin
                        addr <= bus.address_i & line_mask;
                        wbuf <= bus.line_i;
                    end
                end
                RD: begin
                    if (bus.resp_i) begin
                        line[s_burst*cnt +: s_burst] <= bus.burst_i;
                        cnt <= cnt + 1'b1;
                    end
                end
                WR: begin
                    if (bus.resp_i) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef CACHELINE_ADAPTOR_POSTED_WRITE_EN
    logic write_ack;

    // Early acknowledge fires only in the first WR cycle; the burst itself keeps busy_o high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            write_ack <= 1'b0;
        end else begin
            write_ack <= (state == IDLE) && bus.write_i;
        end
    end
`endif

    always_comb begin
        bus.read_o  = (state == RD);
        bus.write_o = (state == WR);
        bus.busy_o  = (state != IDLE);
        bus.burst_o = '0;
        if (state == WR) begin
            bus.burst_o = wbuf[s_burst*cnt +: s_burst];
        end
`ifdef CACHELINE_ADAPTOR_POSTED_WRITE_EN
        bus.resp_o = (state == DONE) || write_ack;
`else
        bus.resp_o = (state == DONE);
`endif
    end

    assign bus.address_o = addr;
    assign bus.line_o    = line;
endmodule

// File: doc/cacheline_adaptor_p.md
# cacheline_adaptor_p

Memory-side partner of the pipelined cache datapath. Accepts whole 256-bit cacheline fill/writeback requests from cache control/datapath. Converts each into a 4-beat, 64-bit burst transaction on the physical-memory port. Returns one completion pulse per request, plus the assembled line for fills.

## Interface
Parameters:
- `s_line`, 256: cacheline width in bits.
- `s_burst`, 64: memory beat width in bits.
- `num_beats`, 4: beats per line, equal to `s_line/s_burst`.

Ports:
- `clk` in 1: single clock; everything is rising-edge.
- `rst` in 1: asynchronous, active-low reset.
- `line_i` in 256: writeback data, i.e. the cache's `cacheline_data_out`.
- `line_o` out 256: assembled fill line, i.e. the cache's `data_from_mem`.
- `address_i` in 32: line address, i.e. the cache's `address_to_mem`.
- `read_i` in 1: fill request, level, held until `resp_o`.
- `write_i` in 1: writeback request, level, held until `resp_o`.
- `resp_o` out 1: one-cycle completion pulse.
- `busy_o` out 1: high whenever the FSM is not IDLE.
- `burst_i` in 64: memory read beat.
- `burst_o` out 64: memory write beat.
- `address_o` out 32: burst address, with bits [4:0] forced to 0.
- `read_o` out 1: memory read request.
- `write_o` out 1: memory write request.
- `resp_i` in 1: memory beat strobe; one pulse per beat; beats may be separated by idle cycles.

## Operation
FSM states: IDLE, RD, WR, DONE.

IDLE:
- If `write_i`=1, go to WR. Write has priority when both requests are high, because a writeback precedes its fill.
- Else if `read_i`=1, go to RD.
- On accept, latch:
  - `address_i` with bits [4:0] cleared into the address register.
  - `line_i` into the write buffer.
- Clear the 2-bit beat counter.
- `resp_i` is ignored in IDLE.

RD:
- `read_o`=1.
- On each edge with `resp_i`=1:
  - `line_o[64*cnt +: 64]` <= `burst_i`.
  - `cnt`++.
- On the 4th beat (cnt==3 and `resp_i`), go to DONE.

WR:
- `write_o`=1.
- `burst_o` = `wbuf[64*cnt +: 64]`.
- On each `resp_i`, `cnt`++.
- On the 4th beat, go to DONE.

DONE:
- `resp_o`=1 for exactly one cycle.
- Then go to IDLE unconditionally.

Beat ordering:
- Beat k carries line bits [64k+63:64k], with k = 0..3 in order.
- The counter wraps 3->0 at burst end.

Held values:
- `line_o` holds its value until the next read burst overwrites it beat by beat.
- `line_o` is unchanged by writes.

Reset, when `rst` is low, at any time including mid-burst:
- State returns to IDLE, `cnt`=0.
- `read_o`=`write_o`=`resp_o`=`busy_o`=0.
- `address_o`=0, `burst_o`=0, `line_o`=0.
- The aborted burst is abandoned and no `resp_o` is produced.

## Timing
- Request accepted at edge N. `read_o`/`write_o` and `address_o` are valid from cycle N+1.
- `address_o` and `burst_o` are registered/mux outputs, stable for the whole burst.
- The 4th `resp_i` is sampled at edge M. `resp_o`=1 during cycle M+1, and `line_o` is complete in that same cycle.
- Minimum latency from accept to `resp_o` is 5 cycles, with back-to-back beats.
- `read_o`/`write_o` drop in cycle M+1. Memory must not issue `resp_i` after the 4th beat until the next request.
- The requester drops `read_i`/`write_i` in the cycle after it sees `resp_o`. Because DONE->IDLE costs a cycle, no re-accept occurs.
- Throughput is one line per burst + 2 cycles. No request overlap.

## Configuration
Macro: `CACHELINE_ADAPTOR_POSTED_WRITE_EN`.

When defined:
- A write is acknowledged early: `resp_o` pulses in cycle N+1, the cycle after accept, while the WR burst proceeds.
- WR exits directly to IDLE with no second `resp_o`.
- `busy_o` stays high until the burst ends. IDLE does not accept any request while a posted burst is outstanding; this is inherent, since the FSM stays in WR.
- The requester's following read waits with `read_i` held.

When undefined:
- Writes complete via DONE like reads.

## Test plan
- Fill: `read_i`=1, `address_i`=0x0000_1234, memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 back-to-back -> `address_o`=0x0000_1220, `line_o`=0x44..44_33..33_22..22_11..11, one `resp_o` pulse 5 cycles after accept.
- Writeback: `write_i`=1, `line_i`=0xDDDD..._CCCC..._BBBB..._AAAA... -> `burst_o` sequence AAAA, BBBB, CCCC, DDDD, advancing only on `resp_i`. `write_o` drops the cycle after the 4th beat. `line_o` unchanged.
- Stalled beats: `resp_i` pattern 1,0,0,1,0,1,1 -> exactly 4 captures in order. `resp_o` appears the cycle after the last strobe and never earlier.
- Simultaneous `read_i`=`write_i`=1 -> WR burst first, `resp_o`. Then, with `read_i` still held, RD burst second, `resp_o`.
- Reset low after 2 read beats -> all outputs 0 immediately (asynchronously). No `resp_o`. After release, a fresh read completes normally starting at beat 0.
- With `CACHELINE_ADAPTOR_POSTED_WRITE_EN`: write accepted -> `resp_o` in cycle N+1. `busy_o` high until the 4th beat. A read asserted at N+2 is accepted only after the write burst ends.
